fpga_stream_source: RTL and testbench

Parametrised command-driven RAM source: an Avalon-MM slave programs an on-chip block RAM, reads single words back, and streams a programmable window of it out an AXI4-Stream master with full `tready` backpressure and `tlast` on the final beat. It sits between the HPS lightweight bridge and FPGA stream consumers. Over the fixed 8-bit, 32-entry, dump-everything generation it adds:
- data width and depth parameters;
- start address and length;
- a beat counter and a sticky error flag.

---
 rtl/fpga_stream_source_if.sv | 40 ++++
 rtl/fpga_stream_source.sv | 254 +++++++++++++++++++++++++
 tb/tb_fpga_stream_source.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_stream_source_if.sv
// Avalon-MM control port and AXI4-Stream output bundle for fpga_stream_source.
// Modports: slave = design side (Avalon slave, stream master);
//           master = host/sink side (drives Avalon, accepts stream).
interface fpga_stream_source_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        avs_address;
    logic              avs_chipselect;
    logic              avs_write_n;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [DATA_W-1:0] axis4_m_tdata;
    logic              axis4_m_tvalid;
    logic              axis4_m_tlast;
    logic              axis4_m_tready;

    modport slave (
        input  avs_address,
        input  avs_chipselect,
        input  avs_write_n,
        input  avs_writedata,
        output avs_readdata,
        output axis4_m_tdata,
        output axis4_m_tvalid,
        output axis4_m_tlast,
        input  axis4_m_tready
    );

    modport master (
        output avs_address,
        output avs_chipselect,
        output avs_write_n,
        output avs_writedata,
        input  avs_readdata,
        input  axis4_m_tdata,
        input  axis4_m_tvalid,
        input  axis4_m_tlast,
        output axis4_m_tready
    );
endinterface

// File: rtl/fpga_stream_source.sv
// Command-driven block-RAM source: Avalon-MM registers write/read single words
// and stream a start/length window out AXI4-Stream with full backpressure.
// Ports: clk, reset (async, active-high), bus (fpga_stream_source_if.slave).
module fpga_stream_source #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input logic                 clk,
    input logic                 reset,
    fpga_stream_source_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_STAT  = 3'd1;
    localparam logic [2:0] A_ADDR  = 3'd2;
    localparam logic [2:0] A_WDATA = 3'd3;
    localparam logic [2:0] A_RDATA = 3'd4;
    localparam logic [2:0] A_BEATS = 3'd5;

    typedef enum logic [1:0] {IDLE, WR, RD, DUMP} state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       beats_q, beats_d;

    // Command snapshot taken when GO is accepted.
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [ADDR_W-1:0] cmd_len_q, cmd_len_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              rd_ph_q, rd_ph_d;

    // Dump read-ahead: issue counter, word in RAM output, skid, output beat.
    logic [ADDR_W-1:0] iss_cnt_q, iss_cnt_d;
    logic              iss_done_q, iss_done_d;
    logic              rv_q, rv_d;
    logic              rlast_q, rlast_d;
    logic              skid_v_q, skid_v_d;
    logic              skid_last_q, skid_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_dout;
    logic              ram_re;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_raddr;

    logic        wr_en;
    logic        go;
    logic        pop;
    logic        busy;
    logic [1:0]  cmd;
    logic [1:0]  occ;
    logic [31:0] rd_mux;
    logic        unused_wd;

    assign wr_en = bus.avs_chipselect && !bus.avs_write_n;
    assign cmd   = bus.avs_writedata[2:1];
    assign go    = wr_en && (bus.avs_address == A_CTRL) && bus.avs_writedata[0];
    assign pop   = tvalid_q && bus.axis4_m_tready;
    assign busy  = (state_q != IDLE);
    assign unused_wd = ^bus.avs_writedata;

    // Words held or landing after this edge's pop; at most two fit downstream.
    assign occ = 2'(tvalid_q) + 2'(skid_v_q) + 2'(rv_q) - 2'(pop);

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        beats_d     = beats_q + 32'(pop);
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_wdata_d = cmd_wdata_q;
        rd_ph_d     = rd_ph_q;
        iss_cnt_d   = iss_cnt_q;
        iss_done_d  = iss_done_q;
        rv_d        = 1'b0;
        rlast_d     = rlast_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        skid_data_d = skid_data_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_raddr   = cmd_addr_q + iss_cnt_q;

        if (wr_en) begin
            case (bus.avs_address)
                A_STAT: if (bus.avs_writedata[1]) err_d = 1'b0;
                A_ADDR: begin
                    addr_d = bus.avs_writedata[ADDR_W-1:0];
                    len_d  = bus.avs_writedata[ADDR_W+15:16];
                end
                A_WDATA: wdata_d = bus.avs_writedata[DATA_W-1:0];
                A_BEATS: beats_d = '0;
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: ;
            WR: begin
                ram_we  = 1'b1;
                state_d = IDLE;
            end
            RD: begin
                if (!rd_ph_q) begin
                    ram_re  = 1'b1;
                    rd_ph_d = 1'b1;
                end else begin
                    rdata_d = ram_dout;
                    state_d = IDLE;
                end
            end
            DUMP: begin
                // Oldest-first: output beat, skid, then the word leaving RAM.
                if (tvalid_q && !pop) begin
                    if (!skid_v_q && rv_q) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = ram_dout;
                        skid_last_d = rlast_q;
                    end
                end else if (skid_v_q) begin
                    tvalid_d    = 1'b1;
                    tdata_d     = skid_data_q;
                    tlast_d     = skid_last_q;
                    skid_v_d    = rv_q;
                    skid_data_d = ram_dout;
                    skid_last_d = rlast_q;
                end else begin
                    tvalid_d = rv_q;
                    tlast_d  = rv_q && rlast_q;
                    if (rv_q) tdata_d = ram_dout;
                end

                if (!iss_done_q && occ <= 2'd1) begin
                    ram_re    = 1'b1;
                    rv_d      = 1'b1;
                    rlast_d   = (iss_cnt_q == cmd_len_q);
                    iss_done_d = (iss_cnt_q == cmd_len_q);
                    iss_cnt_d = iss_cnt_q + ADDR_W'(1);
                end

                if (pop && tlast_q) state_d = IDLE;
            end
        endcase

        // Busy GO and the reserved command both flag an error; set beats clear.
        if (go) begin
            if (busy || cmd == 2'b11) begin
                err_d = 1'b1;
            end else begin
                cmd_addr_d  = addr_q;
                cmd_len_d   = len_q;
                cmd_wdata_d = wdata_q;
                rd_ph_d     = 1'b0;
                iss_cnt_d   = '0;
                iss_done_d  = 1'b0;
                unique case (cmd)
                    2'b00:   state_d = RD;
                    2'b01:   state_d = WR;
                    default: state_d = DUMP;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            beats_q     <= '0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_wdata_q <= '0;
            rd_ph_q     <= 1'b0;
            iss_cnt_q   <= '0;
            iss_done_q  <= 1'b0;
            rv_q        <= 1'b0;
            rlast_q     <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_last_q <= 1'b0;
            skid_data_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            beats_q     <= beats_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_wdata_q <= cmd_wdata_d;
            rd_ph_q     <= rd_ph_d;
            iss_cnt_q   <= iss_cnt_d;
            iss_done_q  <= iss_done_d;
            rv_q        <= rv_d;
            rlast_q     <= rlast_d;
            skid_v_q    <= skid_v_d;
            skid_last_q <= skid_last_d;
            skid_data_q <= skid_data_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
        end
    end

    // Block RAM: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[cmd_addr_q] <= cmd_wdata_q;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    always_comb begin
        rd_mux = '0;
        case (bus.avs_address)
            A_STAT: rd_mux[1:0] = {err_q, busy};
            A_ADDR: begin
                rd_mux[ADDR_W-1:0]     = addr_q;
                rd_mux[ADDR_W+15:16]   = len_q;
            end
            A_WDATA: rd_mux[DATA_W-1:0] = wdata_q;
            A_RDATA: rd_mux[DATA_W-1:0] = rdata_q;
            A_BEATS: rd_mux = beats_q;
            default: ;
        endcase
    end

    assign bus.avs_readdata   = rd_mux;
    assign bus.axis4_m_tdata  = tdata_q;
    assign bus.axis4_m_tvalid = tvalid_q;
    assign bus.axis4_m_tlast  = tlast_q;
endmodule

// File: tb/tb_fpga_stream_source.sv
// Testbench for fpga_stream_source: 8-bit/32-deep and 32-bit/256-deep builds,
// random data and backpressure checked against a window model of the RAM.
module tb_fpga_stream_source;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  address;
    logic        cs;
    logic        write_n;
    logic [31:0] wdata;
    logic        tready;
    logic        sel;

    fpga_stream_source_if #(.DATA_W(8))  ifa ();
    fpga_stream_source_if #(.DATA_W(32)) ifb ();

    fpga_stream_source #(.DATA_W(8), .ADDR_W(5)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    fpga_stream_source #(.DATA_W(32), .ADDR_W(8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    assign ifa.avs_address    = address;
    assign ifa.avs_chipselect = cs && !sel;
    assign ifa.avs_write_n    = write_n;
    assign ifa.avs_writedata  = wdata;
    assign ifa.axis4_m_tready = tready && !sel;
    assign ifb.avs_address    = address;
    assign ifb.avs_chipselect = cs && sel;
    assign ifb.avs_write_n    = write_n;
    assign ifb.avs_writedata  = wdata;
    assign ifb.axis4_m_tready = tready && sel;

    logic [31:0] rdata;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    assign rdata  = sel ? ifb.avs_readdata : ifa.avs_readdata;
    assign tdata  = sel ? ifb.axis4_m_tdata : 32'(ifa.axis4_m_tdata);
    assign tvalid = sel ? ifb.axis4_m_tvalid : ifa.axis4_m_tvalid;
    assign tlast  = sel ? ifb.axis4_m_tlast : ifa.axis4_m_tlast;

    int n_pass;
    int n_total;
    int aw;
    int depth;
    logic [31:0] dmask;

    logic [31:0] mmem [2][256];
    logic [31:0] m_beats [2];

    logic [31:0] got_q [$];
    bit          last_q [$];
    int          first_v;
    int          last_hs;
    int          stall_bad;
    bit          timed_out;

    task automatic avs_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; wdata = d; cs = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
        address = a; cs = 1'b1; write_n = 1'b1;
        #1 d = rdata;
        cs = 1'b0;
    endtask

    task automatic busy_cycles(output int n);
        logic [31:0] s;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            avs_read(3'd1, s);
            if (!s[0]) break;
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic ram_write(input int a, input logic [31:0] d, output int nb);
        avs_write(3'd2, 32'(a));
        avs_write(3'd3, d);
        avs_write(3'd0, 32'h3);
        busy_cycles(nb);
        mmem[sel][a] = d & dmask;
    endtask

    task automatic ram_read(input int a, output logic [31:0] d, output int nb);
        avs_write(3'd2, 32'(a));
        avs_write(3'd0, 32'h1);
        busy_cycles(nb);
        avs_read(3'd4, d);
    endtask

    // Launch a dump and collect accepted beats; optional GO injection and early stop.
    task automatic run_dump(input int st, input int len, input bit rnd,
                            input int inject_at, input int abort_after);
        logic [31:0] hold_d;
        bit hold_l;
        bit stalled;
        int hs;
        got_q.delete(); last_q.delete();
        first_v = -1; last_hs = -1; stall_bad = 0; timed_out = 1'b1;
        stalled = 1'b0; hs = 0; hold_d = '0; hold_l = 1'b0;
        avs_write(3'd2, {16'(len - 1), 16'(st)});
        avs_write(3'd0, 32'h5);
        for (int cyc = 0; cyc < 8 * len + 40; cyc++) begin
            @(negedge clk);
            if (cyc == inject_at) begin
                address = 3'd0; wdata = 32'h3; cs = 1'b1; write_n = 1'b0;
            end else begin
                cs = 1'b0; write_n = 1'b1;
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (!tvalid || tdata !== hold_d || tlast !== hold_l))
                stall_bad++;
            if (tvalid && first_v < 0) first_v = cyc;
            stalled = tvalid && !tready;
            hold_d = tdata; hold_l = tlast;
            if (tvalid && tready) begin
                got_q.push_back(tdata);
                last_q.push_back(tlast);
                hs++;
                last_hs = cyc;
                m_beats[sel] = m_beats[sel] + 1;
                if (tlast || hs == abort_after) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        cs = 1'b0; write_n = 1'b1;
        @(posedge clk); #1;
        tready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b1; tready = 1'b0; cs = 1'b0; write_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_beats[0] = '0; m_beats[1] = '0;
        for (int a = 0; a < 8; a++) begin
            avs_read(3'(a), s);
            n_total++;
            if (s !== 32'h0) $display("FAIL reset_reg%0d got %h want 0", a, s);
            else n_pass++;
        end
        n_total++;
        if ({tvalid, tlast, tdata} !== 34'h0)
            $display("FAIL reset_axis got v=%b l=%b d=%h want 0", tvalid, tlast, tdata);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [31:0] v;
        logic [31:0] amask;
        int nb;
        int a;
        ram_write(3, 32'hA5, nb);
        n_total++;
        if (nb !== 1) $display("FAIL wr_busy got %0d want 1", nb);
        else n_pass++;
        ram_read(3, d, nb);
        n_total++;
        if (nb !== 2) $display("FAIL rd_busy got %0d want 2", nb);
        else n_pass++;
        n_total++;
        if (d !== 32'hA5) $display("FAIL rd_a5 got %h want a5", d);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            a = $urandom_range(0, depth - 1);
            v = $urandom & dmask;
            ram_write(a, v, nb);
            ram_read(a, d, nb);
            n_total++;
            if (d !== v) $display("FAIL rd_rand[%0d] got %h want %h", a, d, v);
            else n_pass++;
        end
        v = $urandom;
        amask = (32'd1 << aw) - 32'd1;
        avs_write(3'd2, v);
        avs_read(3'd2, d);
        n_total++;
        if (d !== ((v & amask) | (v & (amask << 16))))
            $display("FAIL addr_reg got %h want %h", d, (v & amask) | (v & (amask << 16)));
        else n_pass++;
        avs_write(3'd3, v);
        avs_read(3'd3, d);
        n_total++;
        if (d !== (v & dmask)) $display("FAIL wdata_reg got %h want %h", d, v & dmask);
        else n_pass++;
        avs_write(3'd6, v);
        avs_read(3'd6, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL unmapped_reg got %h want 0", d);
        else n_pass++;
    endtask

    task automatic fill_ram();
        int nb;
        for (int i = 0; i < depth; i++)
            ram_write(i, (32'(i) | ($urandom << 8)), nb);
    endtask

    task automatic test_dump(input int st, input int len, input bit rnd, input string nm);
        logic [31:0] s;
        int bad;
        int lbad;
        run_dump(st, len, rnd, -1, 0);
        n_total++;
        if (timed_out) $display("FAIL %s timeout got %0d beats want %0d", nm, got_q.size(), len);
        else n_pass++;
        n_total++;
        if (got_q.size() != len) $display("FAIL %s count got %0d want %0d", nm, got_q.size(), len);
        else n_pass++;
        bad = 0; lbad = 0;
        foreach (got_q[i]) begin
            if (got_q[i] !== mmem[sel][(st + i) % depth]) bad++;
            if (last_q[i] !== (i == len - 1)) lbad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL %s data got %0d bad beats want 0", nm, bad);
        else n_pass++;
        n_total++;
        if (lbad != 0) $display("FAIL %s tlast got %0d bad beats want 0", nm, lbad);
        else n_pass++;
        n_total++;
        if (first_v < 0 || first_v > 2) $display("FAIL %s latency got %0d want <=2", nm, first_v);
        else n_pass++;
        if (!rnd) begin
            n_total++;
            if (last_hs - first_v != len - 1)
                $display("FAIL %s b2b got %0d cycles want %0d", nm, last_hs - first_v + 1, len);
            else n_pass++;
        end
        n_total++;
        if (stall_bad != 0) $display("FAIL %s stall_hold got %0d want 0", nm, stall_bad);
        else n_pass++;
        avs_read(3'd1, s);
        n_total++;
        if (s[0] !== 1'b0) $display("FAIL %s busy_after got %b want 0", nm, s[0]);
        else n_pass++;
        avs_read(3'd5, s);
        n_total++;
        if (s !== m_beats[sel]) $display("FAIL %s beats got %0d want %0d", nm, s, m_beats[sel]);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] s;
        int st;
        int bad;
        int nv;
        st = $urandom_range(0, depth - 1);
        run_dump(st, 16, 1'b0, 4, 0);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] !== mmem[sel][(st + i) % depth]) bad++;
        n_total++;
        if (got_q.size() != 16 || bad != 0)
            $display("FAIL go_in_dump got %0d beats %0d bad want 16 0", got_q.size(), bad);
        else n_pass++;
        avs_read(3'd1, s);
        n_total++;
        if (s !== 32'h2) $display("FAIL go_in_dump_err got %h want 2", s);
        else n_pass++;
        avs_write(3'd1, 32'h2);
        avs_read(3'd1, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL err_clear got %h want 0", s);
        else n_pass++;
        avs_write(3'd0, 32'h7);
        avs_read(3'd1, s);
        n_total++;
        if (s !== 32'h2) $display("FAIL cmd11_err got %h want 2", s);
        else n_pass++;
        nv = 0;
        tready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (tvalid) nv++;
        end
        tready = 1'b0;
        n_total++;
        if (nv != 0) $display("FAIL cmd11_stream got %0d valid cycles want 0", nv);
        else n_pass++;
        avs_write(3'd1, 32'h2);
        avs_write(3'd5, $urandom);
        m_beats[sel] = '0;
        avs_read(3'd5, s);
        n_total++;
        if (s !== 32'h0) $display("FAIL beats_clear got %0d want 0", s);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dump();
        logic [31:0] s;
        logic [31:0] v;
        int st;
        int nz;
        int nb;
        st = $urandom_range(0, depth - 1);
        run_dump(st, 16, 1'b0, -1, 5);
        n_total++;
        if (got_q.size() != 5 || tvalid !== 1'b1)
            $display("FAIL mid_dump_pre got %0d beats v=%b want 5 1", got_q.size(), tvalid);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({tvalid, tlast, tdata} !== 34'h0)
            $display("FAIL mid_reset_axis got v=%b l=%b d=%h want 0", tvalid, tlast, tdata);
        else n_pass++;
        nz = 0;
        for (int a = 0; a < 8; a++) begin
            avs_read(3'(a), s);
            if (s !== 32'h0) nz++;
        end
        n_total++;
        if (nz != 0) $display("FAIL mid_reset_regs got %0d nonzero want 0", nz);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        m_beats[0] = '0; m_beats[1] = '0;
        st = $urandom_range(0, depth - 1);
        v = $urandom & dmask;
        ram_write(st, v, nb);
        run_dump(st, 1, 1'b0, -1, 0);
        n_total++;
        if (got_q.size() != 1 || got_q[0] !== v || last_q[0] !== 1'b1)
            $display("FAIL post_reset_len1 got n=%0d d=%h want 1 %h last", got_q.size(),
                     got_q.size() > 0 ? got_q[0] : 32'h0, v);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        address = '0; cs = 1'b0; write_n = 1'b1; wdata = '0;
        tready = 1'b0; sel = 1'b0; reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            sel   = (c == 1);
            aw    = (c == 1) ? 8 : 5;
            depth = 1 << aw;
            dmask = (c == 1) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            test_reset();
            test_write_read();
            fill_ram();
            test_dump(0, depth, 1'b0, "full");
            test_dump(depth - 2, 4, 1'b0, "wrap");
            test_dump(depth - 2, 4, 1'b1, "wrap_bp");
            test_dump(0, depth, 1'b1, "full_bp");
            test_dump($urandom_range(0, depth - 1), 1, 1'b0, "len1");
            for (int k = 0; k < 3; k++)
                test_dump($urandom_range(0, depth - 1), $urandom_range(1, depth), 1'b1, "rand");
            test_errors();
            test_reset_mid_dump();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
